// File: rtl/branch_pkg.sv
// branch_pkg: shared funct3 codes, BHT counter type and branch condition decode.
package branch_pkg;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_RESET = 2'b01;
  localparam logic [31:0] PC_STEP = 32'd4;
  function automatic logic cond_taken(input logic [2:0] f3, input logic lt, input logic eq);
    return f3 == F3_BEQ ? eq :
           f3 == F3_BNE ? ~eq :
           (f3 == F3_BLT || f3 == F3_BLTU) ? lt :
           (f3 == F3_BGE || f3 == F3_BGEU) ? ~lt : 1'b0;
  endfunction
endpackage

// File: rtl/branch_resolve_bht.sv
// bht: 2-bit saturating branch history table, combinational read, synchronous update.
module bht
  import branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  bht_ctr_t tbl [2**IDX_W];
  bht_ctr_t cur;
  assign rd_taken = tbl[rd_idx][1];
  assign cur = tbl[wr_idx];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= BHT_RESET;
    end else if (wr_en) begin
      tbl[wr_idx] <= wr_taken ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
    end
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch decide, registered mispredict redirect/flush, BHT lookup/update.
// The BHT is present only when BRANCH_BHT_EN is defined; otherwise fetch predicts static not-taken.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic        br_unsigned,
  input  logic        br_less,
  input  logic        br_equal,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
);
  logic live, taken, mispredict;
  assign br_unsigned = ex_funct3[1];
  assign live = ex_valid & ~redirect_valid;
  assign taken = ex_is_jump | (ex_is_branch & cond_taken(ex_funct3, br_less, br_equal));
  assign mispredict = live & (ex_is_branch | ex_is_jump) & (taken != ex_pred_taken);
  assign flush = redirect_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= taken ? ex_target : ex_pc + PC_STEP;
    end
  end
`ifdef BRANCH_BHT_EN
  logic unused_pc;
  assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};
  bht #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_taken (if_pred_taken),
    .wr_en    (live & ex_is_branch & ~ex_is_jump),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );
`else
  logic unused_pc;
  assign unused_pc = ^if_pc;
  assign if_pred_taken = 1'b0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed plan checks plus randomized traffic against a behavioural model.
module tb_branch_resolve;
`ifdef BRANCH_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, ex_is_branch = 0, ex_is_jump = 0, ex_pred_taken = 0;
  logic [2:0] ex_funct3 = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, if_pc = 0, op_a = 0, op_b = 0;
  logic br_less = 0, br_equal = 0;
  logic br_unsigned, if_pred_taken, redirect_valid, flush;
  logic [31:0] redirect_pc;
  int checks = 0, failures = 0;
  int m_bht [64];
  bit m_rv = 0;
  logic [31:0] m_rpc = 0;

  branch_resolve #(.IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .br_unsigned(br_unsigned), .br_less(br_less),
    .br_equal(br_equal), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, br, j, input logic [2:0] f3, input logic [31:0] pc, tgt,
                       input logic pr, input logic [31:0] a, b);
    ex_valid = v; ex_is_branch = br; ex_is_jump = j; ex_funct3 = f3;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pr; op_a = a; op_b = b;
  endtask

  // One clock: emulate the comparator, check against the model, advance the model.
  task automatic cycle();
    bit cond, tk, live, mis, nrv;
    logic [31:0] nrpc;
    int idx;
    #1;
    br_equal = op_a == op_b;
    br_less = br_unsigned ? op_a < op_b : $signed(op_a) < $signed(op_b);
    #1;
    chk("br_unsigned", br_unsigned, ex_funct3[1]);
    chk("if_pred_taken", if_pred_taken, BHT_ON && m_bht[if_pc[7:2]] >= 2);
    case (ex_funct3)
      3'b000: cond = op_a == op_b;
      3'b001: cond = op_a != op_b;
      3'b100: cond = $signed(op_a) < $signed(op_b);
      3'b101: cond = $signed(op_a) >= $signed(op_b);
      3'b110: cond = op_a < op_b;
      3'b111: cond = op_a >= op_b;
      default: cond = 0;
    endcase
    tk = ex_is_jump || (ex_is_branch && cond);
    live = ex_valid && !m_rv;
    mis = live && (ex_is_branch || ex_is_jump) && tk != ex_pred_taken;
    nrv = rst_n && mis;
    nrpc = !rst_n ? 32'd0 : mis ? (tk ? ex_target : ex_pc + 32'd4) : m_rpc;
    idx = ex_pc[7:2];
    if (!rst_n) foreach (m_bht[i]) m_bht[i] = 1;
    else if (live && ex_is_branch && !ex_is_jump)
      m_bht[idx] = tk ? (m_bht[idx] < 3 ? m_bht[idx] + 1 : 3) : (m_bht[idx] > 0 ? m_bht[idx] - 1 : 0);
    @(posedge clk);
    #1;
    m_rv = nrv; m_rpc = nrpc;
    chk("redirect_valid", redirect_valid, m_rv);
    chk("flush", flush, m_rv);
    chk("redirect_pc", redirect_pc, m_rpc);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    cycle();
  endtask

  function automatic logic [31:0] pick_op(input int k);
    logic [31:0] tbl [4];
    tbl[0] = 32'h0; tbl[1] = 32'h1; tbl[2] = 32'hFFFFFFFF; tbl[3] = 32'h80000000;
    return tbl[k];
  endfunction

  initial begin
    foreach (m_bht[i]) m_bht[i] = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    if_pc = 32'h14;
    #1;
    chk("reset_rv", redirect_valid, 0);
    chk("reset_flush", flush, 0);
    chk("reset_rpc", redirect_pc, 0);
    chk("reset_pred", if_pred_taken, 0);
    @(negedge clk);
    idle();
    // BLTU versus BLT on the same operands
    drive(1, 1, 0, 3'b110, 32'h200, 32'h300, 0, 32'hFFFFFFFF, 32'h1);
    #1;
    chk("bltu_unsigned", br_unsigned, 1);
    cycle();
    chk("bltu_not_taken", redirect_valid, 0);
    drive(1, 1, 0, 3'b100, 32'h200, 32'h300, 0, 32'hFFFFFFFF, 32'h1);
    #1;
    chk("blt_signed", br_unsigned, 0);
    cycle();
    chk("blt_taken_rv", redirect_valid, 1);
    chk("blt_taken_pc", redirect_pc, 32'h300);
    idle();
    // taken mispredict then quiet cycle
    drive(1, 1, 0, 3'b000, 32'h100, 32'h40, 0, 32'h7, 32'h7);
    cycle();
    chk("beq_mis_rv", redirect_valid, 1);
    chk("beq_mis_flush", flush, 1);
    chk("beq_mis_pc", redirect_pc, 32'h40);
    idle();
    chk("beq_after_rv", redirect_valid, 0);
    chk("beq_after_flush", flush, 0);
    chk("beq_hold_pc", redirect_pc, 32'h40);
    // not-taken mispredict with PC wrap
    drive(1, 1, 0, 3'b001, 32'hFFFFFFFC, 32'h500, 1, 32'h3, 32'h3);
    cycle();
    chk("wrap_rv", redirect_valid, 1);
    chk("wrap_pc", redirect_pc, 32'h0);
    idle();
    // wrong-path JAL after a mispredict is squashed
    drive(1, 0, 1, 3'b000, 32'h80, 32'h900, 0, 0, 0);
    cycle();
    chk("sq_first_rv", redirect_valid, 1);
    drive(1, 0, 1, 3'b000, 32'h84, 32'hA00, 0, 0, 0);
    cycle();
    chk("sq_second_rv", redirect_valid, 0);
    chk("sq_pc_held", redirect_pc, 32'h900);
    idle();
    // saturation on index 5 (pc 0x14)
    if_pc = 32'h14;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3'b000, 32'h14, 32'h0, 1, 5, 5);
      cycle();
      if (i == 0) chk("sat_first_pred", if_pred_taken, BHT_ON);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 3'b000, 32'h14, 32'h0, 0, 5, 6);
      cycle();
      if (i == 0) chk("sat_held_11", if_pred_taken, BHT_ON);
      if (i == 1) chk("sat_down_01", if_pred_taken, 0);
    end
    drive(1, 1, 0, 3'b000, 32'h14, 32'h0, 1, 5, 5);
    cycle();
    chk("sat_floor_00", if_pred_taken, 0);
    cycle();
    chk("sat_up_10", if_pred_taken, BHT_ON);
    // same-cycle update and lookup returns the old value
    drive(1, 1, 0, 3'b000, 32'h14, 32'h0, 0, 5, 6);
    #1;
    chk("collide_old", if_pred_taken, BHT_ON);
    cycle();
    chk("collide_new", if_pred_taken, 0);
    // reset mid-stream with a mispredict in EX
    drive(1, 1, 0, 3'b000, 32'h14, 32'h0, 1, 5, 5);
    cycle();
    cycle();
    drive(1, 0, 1, 3'b000, 32'h40, 32'h123, 0, 0, 0);
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rst_mid_rv", redirect_valid, 0);
    chk("rst_mid_pc", redirect_pc, 0);
    for (int i = 0; i < 64; i++) begin
      if_pc = i * 4;
      drive(1, 1, 0, 3'b000, i * 4, 32'h0, 1, 1, 1);
      cycle();
      chk("rst_entry_01", if_pred_taken, BHT_ON);
    end
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int kind;
      kind = $urandom_range(0, 99);
      rst_n = $urandom_range(0, 199) != 0;
      ex_valid = $urandom_range(0, 9) < 8;
      ex_is_branch = kind < 60;
      ex_is_jump = kind >= 60 && kind < 75;
      ex_funct3 = 3'($urandom_range(0, 7));
      ex_pc = {$urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'($urandom), 3'd0, 3'($urandom_range(0, 7)), 2'b00};
      ex_target = $urandom & 32'hFFFFFFFC;
      ex_pred_taken = 1'($urandom);
      if_pc = {24'($urandom), 3'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      op_a = pick_op($urandom_range(0, 3));
      op_b = pick_op($urandom_range(0, 3));
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
